// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, result kinds, encryption key.
// Used by the ALU and by its result decoder.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_ENC = 4'd8;

  localparam logic [7:0] ENC_KEY = 8'hAB;

  typedef enum logic [1:0] {
    KIND_PLAIN   = 2'd0,
    KIND_WIDE    = 2'd1,
    KIND_SPLIT   = 2'd2,
    KIND_INVALID = 2'd3
  } kind_e;

  typedef struct packed {
    logic [8:0] data;
    kind_e      kind;
    logic       err;
  } dec_t;

endpackage

// File: rtl/alu_result_decoder_if.sv
// Beat-in / word-out handshake bundle of the ALU result decoder.
// master drives beats and out_ready; slave is the decoder.
interface alu_result_decoder_if;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [7:0] in_result;
  logic       in_carry;
  logic       in_overflow;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [1:0] out_kind;
  logic       out_err;

  modport master (
    output in_valid, in_opcode, in_result,
    output in_carry, in_overflow, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_kind, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_result,
    input  in_carry, in_overflow, out_ready,
    output in_ready, out_valid, out_data,
    output out_kind, out_err
  );

endinterface

// File: rtl/alu_result_decoder_sync_fifo.sv
// Count-based synchronous FIFO, async active-low reset.
// Read data is combinational from the head and zero when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are masked by empty so need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_result_decoder.sv
// Decodes ALU result beats by opcode and buffers decoded words.
// Counts accepted malformed beats in a saturating counter.
module alu_result_decoder
  import alu_pkg::*;
#(
  parameter logic [7:0] KEY   = ENC_KEY,
  parameter int         DEPTH = 4,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_decoder_if.slave bus,
  input  logic             err_clear,
  output logic [CNT_W-1:0] err_count
);

  function automatic dec_t decode(
    input logic [3:0] op,
    input logic [7:0] res,
    input logic       cy,
    input logic       ov
  );
    dec_t d;
    d.data = '0;
    d.kind = KIND_INVALID;
    d.err  = 1'b1;
    unique case (1'b1)
      (op == OP_ADD) || (op == OP_SUB): begin
        d.data = {4'b0, cy, res[3:0]};
        d.kind = KIND_WIDE;
        d.err  = |res[7:4];
      end
      (op == OP_MUL): begin
        d.data = {1'b0, res};
        d.kind = KIND_PLAIN;
        d.err  = cy | ov;
      end
      (op == OP_DIV): begin
        d.data = {1'b0, res};
        d.kind = KIND_SPLIT;
        d.err  = cy | ov;
      end
      (op >= OP_AND) && (op <= OP_NOT): begin
        d.data = {5'b0, res[3:0]};
        d.kind = KIND_PLAIN;
        d.err  = (|res[7:4]) | cy | ov;
      end
      (op == OP_ENC): begin
        d.data = {1'b0, res ^ KEY};
        d.kind = KIND_SPLIT;
        d.err  = cy | ov;
      end
      default: begin
        d.data = '0;
        d.kind = KIND_INVALID;
        d.err  = 1'b1;
      end
    endcase
    return d;
  endfunction

  dec_t dec;
  dec_t head;
  logic push;
  logic full;
  logic empty;

  // Decode the incoming beat before it enters the buffer.
  always_comb begin
    dec = decode(bus.in_opcode, bus.in_result,
                 bus.in_carry, bus.in_overflow);
  end

  assign push = bus.in_valid && bus.in_ready;

  sync_fifo #(
    .W     ($bits(dec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (dec),
    .pop   (bus.out_ready),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = head.data;
  assign bus.out_kind  = head.kind;
  assign bus.out_err   = head.err;

  // Saturating error counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if (push && dec.err && !(&err_count)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_decoder.sv
// Scoreboard bench for alu_result_decoder: random and directed beats
// checked against a behavioural decode model.
module tb_alu_result_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] err_count;

  alu_result_decoder_if bus ();

  alu_result_decoder #(
    .KEY   (8'hAB),
    .DEPTH (DEPTH),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_clear (err_clear),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] q[$];
  int ecnt = 0;
  bit rnd = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: {data[8:0], kind[1:0], err}
  function automatic logic [11:0] model(input int op, input int res,
                                        input int cy, input int ov);
    int d, k, e;
    case (op)
      0, 1: begin d = cy * 16 + res % 16; k = 1; e = (res >= 16); end
      2:    begin d = res; k = 0; e = (cy || ov); end
      3:    begin d = res; k = 2; e = (cy || ov); end
      4, 5, 6, 7: begin
        d = res % 16; k = 0; e = (res >= 16 || cy || ov);
      end
      8:    begin d = res ^ 'hAB; k = 2; e = (cy || ov); end
      default: begin d = 0; k = 3; e = 1; end
    endcase
    return {d[8:0], k[1:0], e[0]};
  endfunction

  // Monitor: compare outputs and flags, then record accepted beats.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst_n) begin
      q.delete();
      ecnt = 0;
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'(q.size() != DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check("err_count", 32'(err_count), 32'(ecnt));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() != 0) begin
          e = q.pop_front();
          check("word", {20'b0, bus.out_data, bus.out_kind, bus.out_err},
                32'(e));
        end
      end else if (!bus.out_valid) begin
        check("idle_zero",
              {20'b0, bus.out_data, bus.out_kind, bus.out_err}, 32'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(int'(bus.in_opcode), int'(bus.in_result),
                  int'(bus.in_carry), int'(bus.in_overflow));
        q.push_back(e);
        if (err_clear) ecnt = 0;
        else if (e[0] && ecnt < 255) ecnt++;
      end else if (err_clear) begin
        ecnt = 0;
      end
    end
  end

  // Random downstream readiness while rnd is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive(input logic [3:0] op, input logic [7:0] res,
                       input logic cy, input logic ov);
    int t = 0;
    logic acc;
    bus.in_valid    = 1'b1;
    bus.in_opcode   = op;
    bus.in_result   = res;
    bus.in_carry    = cy;
    bus.in_overflow = ov;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) check("drive_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_opcode   = '0;
    bus.in_result   = '0;
    bus.in_carry    = 1'b0;
    bus.in_overflow = 1'b0;
    bus.out_ready   = 1'b1;

    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(4'd8, 8'h9E, 1'b0, 1'b0);
    drive(4'd0, 8'h01, 1'b1, 1'b1);
    drive(4'd1, 8'h0E, 1'b1, 1'b0);
    drive(4'd3, 8'h21, 1'b0, 1'b0);
    drive(4'd4, 8'h13, 1'b0, 1'b0);
    drain();
    check("err_after_op4", 32'(err_count), 32'd1);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(4'd2, 8'(8'h10 + i), 1'b0, 1'b0);
    fork
      drive(4'd2, 8'h14, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      err_clear = ($urandom_range(0, 15) == 0);
      drive(4'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom), 1'($urandom));
      err_clear = 1'b0;
    end
    rnd = 0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    for (int i = 0; i < 256; i++) drive(4'hF, 8'($urandom), 1'b0, 1'b0);
    drain();
    check("err_saturated", 32'(err_count), 32'hFF);
    err_clear = 1'b1;
    drive(4'hF, 8'h00, 1'b0, 1'b0);
    err_clear = 1'b0;
    drain();
    check("err_cleared", 32'(err_count), 32'd0);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(4'hA, 8'(i), 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    ecnt = 0;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(4'd2, 8'h5A, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
